decapsulation2: RTL and testbench
=================================

// Module: decapsulation2
// PURPOSE
// - Receive-side counterpart of the transmit encapsulation unit.
// - Takes the destuffed CAN bit stream from the receive path and decodes the frame header.
// - Decoded fields: SOF, identifier, SRR/RTR, IDE, r1/r0, DLC, data bytes and CRC field.
// - Presents the decoded fields as registers to the IOCPU receive buffers and the LLC.
// - Basic and extended frames supported. Frame sequence is tracked by a field state machine with a bit counter.
// PARAMETERS
// - MAX_BYTES  8  data bytes stored; DLC > MAX_BYTES is clipped to MAX_BYTES for the real length
// PORTS
// - clock       in   1   main clock, rising edge
// - reset       in   1   synchronous, active-low
// - bit_in      in   1   destuffed received bit
// - bit_valid   in   1   strobe: bit_in consumed on this clock edge
// - sof         in   1   start-of-frame flag, qualified by bit_valid; that bit is the SOF bit
// - abort       in   1   error/overload detected: drop frame
// - identifier  out  29  [28:18] base id; [17:0] extended id, 0 for basic frames
// - extended    out  1   IDE bit
// - remote      out  1   RTR bit
// - datalen     out  4   DLC field as received
// - rmlen       out  4   real data length: 0 if remote, else min(DLC, MAX_BYTES)
// - data        out  64  byte0 at [63:56], MSB first; bytes not received read 0
// - crc_rx      out  15  received CRC field, MSB first
// - crc_en      out  1   high while state is in SOF..DATA (bits that feed the CRC check)
// - dlc_done    out  1   1-cycle pulse: DLC field complete
// - frame_done  out  1   1-cycle pulse: last CRC bit sampled
// BEHAVIOUR
// - Reset: state IDLE, counter 0, all outputs 0.
// - All outputs are registered.
// - Fields are consumed only on edges with bit_valid=1. Nothing advances while bit_valid=0.
// - Priority per edge: reset > abort > (sof & bit_valid) > normal bit.
// - abort: go to IDLE; no frame_done; field outputs hold their partial values.
// - sof & bit_valid in any state, including mid-frame:
//   - clear identifier, extended, remote, datalen, data and crc_rx;
//   - go to ID_A with cnt=0.
// - States and bit counts:
//   - IDLE: only sof leaves this state.
//   - ID_A (11 bits): shift into identifier[28:18], MSB first.
//   - BIT12 (1): capture into rtr_tmp.
//   - IDE (1): extended <= bit.
//     - bit=0: remote <= rtr_tmp; go to R0.
//     - bit=1: go to ID_B.
//   - ID_B (18): shift into identifier[17:0].
//   - RTR (1): remote <= bit.
//   - R1 (1), then R0 (1): values ignored, not checked.
//   - DLC (4): shift into datalen, MSB first.
//     - On the 4th bit: compute rmlen and pulse dlc_done in the next cycle.
//     - rmlen==0: go to CRC; else go to DATA.
//   - DATA (8*rmlen): bit k written to data[63-k].
//   - CRC (15): shift into crc_rx.
//     - On the 15th bit: frame_done=1 for one cycle, then IDLE.
// - Valid bits per frame:
//   - basic: 34 + 8*rmlen.
//   - extended: 54 + 8*rmlen.
// - Latency: the output register is updated on the edge that samples the bit and is visible the next cycle.
// - Field validity:
//   - datalen/rmlen are valid from dlc_done.
//   - All fields are stable from frame_done until the next sof.
// - Counter: 6 bits, reset to 0 at every field change. Range 0..63 covers 64 data bits.
// - Boundaries:
//   - DLC 9..15: datalen keeps the raw value; rmlen=8.
//   - remote=1 with DLC>0: rmlen=0; no data consumed.
//   - A bit_valid gap of any length: no effect.
//   - Reset mid-frame: IDLE, outputs 0.
// STRUCTURE
// - Shared package can_pkg, containing:
//   - state encoding localparams;
//   - field widths: ID_A_W=11, ID_B_W=18, DLC_W=4, CRC_W=15;
//   - MAX_BYTES.
// - One sub-module, decap_fieldcnt:
//   - 6-bit bit counter with load/clear and a terminal-count compare against the field length;
//   - used by the main FSM.
// - Shifters and output registers stay in the top module.
// TESTING
// - Basic frame: id 0x123, RTR0, DLC 2, data A5 5A, CRC 0x1234.
//   -> identifier=0x123<<18, extended=0, rmlen=2, data[63:48]=A55A, rest 0, crc_rx=0x1234.
//   -> frame_done after the 50th valid bit.
// - Extended remote frame: id 0x1ABCDEF5, DLC 5, CRC 0x7FFF.
//   -> extended=1, remote=1, datalen=5, rmlen=0, data=0, crc_rx=0x7FFF.
//   -> frame_done after the 54th bit.
// - Basic frame, DLC 15 with 64 data bits 0x0123456789ABCDEF.
//   -> datalen=15, rmlen=8, data=0x0123456789ABCDEF, dlc_done pulse after bit 19.
// - Basic frame (same as the first scenario) sent with random 0-5 cycle bit_valid gaps.
//   -> outputs identical to the gap-free run.
// - Abort in DATA, then a new frame id 0x7FF, DLC 0.
//   -> no frame_done for the first frame; the second frame decodes with identifier=0x7FF<<18.
// - reset=0 mid-ID_B: all outputs 0 next cycle; a following frame decodes normally.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN receive definitions: field widths, state encodings and the
// real-data-length helper used by the decapsulation unit.
package can_pkg;

   localparam int MAX_BYTES = 8;
   localparam int ID_A_W    = 11;
   localparam int ID_B_W    = 18;
   localparam int DLC_W     = 4;
   localparam int CRC_W     = 15;
   localparam int CNT_W     = 6;

   localparam logic [3:0] ST_IDLE  = 4'd0;
   localparam logic [3:0] ST_ID_A  = 4'd1;
   localparam logic [3:0] ST_BIT12 = 4'd2;
   localparam logic [3:0] ST_IDE   = 4'd3;
   localparam logic [3:0] ST_ID_B  = 4'd4;
   localparam logic [3:0] ST_RTR   = 4'd5;
   localparam logic [3:0] ST_R1    = 4'd6;
   localparam logic [3:0] ST_R0    = 4'd7;
   localparam logic [3:0] ST_DLC   = 4'd8;
   localparam logic [3:0] ST_DATA  = 4'd9;
   localparam logic [3:0] ST_CRC   = 4'd10;

   typedef enum logic [3:0] {
      S_IDLE  = ST_IDLE,
      S_ID_A  = ST_ID_A,
      S_BIT12 = ST_BIT12,
      S_IDE   = ST_IDE,
      S_ID_B  = ST_ID_B,
      S_RTR   = ST_RTR,
      S_R1    = ST_R1,
      S_R0    = ST_R0,
      S_DLC   = ST_DLC,
      S_DATA  = ST_DATA,
      S_CRC   = ST_CRC
   } state_t;

   // Remote frames carry no data regardless of DLC; oversize DLC is clipped.
   function automatic logic [3:0] real_len(input logic [3:0] dlc, input logic rtr,
                                           input int max_bytes);
      if (rtr)
         return 4'd0;
      else if (int'(dlc) > max_bytes)
         return 4'(max_bytes);
      else
         return dlc;
   endfunction

endpackage

// File: rtl/decap_fieldcnt.sv
// Per-field bit counter: counts consumed bits and flags the last bit of the
// current field by comparing against the field length minus one.
module decap_fieldcnt
   import can_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             i_clr,
   input  logic             i_inc,
   input  logic [CNT_W-1:0] i_last,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_tc
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clock) begin
      if (!reset)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_inc)
         r_cnt <= r_cnt + 1'b1;
   end

   assign o_cnt = r_cnt;
   assign o_tc  = (r_cnt == i_last);

endmodule

// File: rtl/decapsulation2.sv
// CAN receive decapsulation: walks the destuffed bit stream through the frame
// header, data and CRC fields and presents each decoded field as a register.
module decapsulation2 #(
   parameter int MAX_BYTES = can_pkg::MAX_BYTES
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        bit_in,
   input  logic        bit_valid,
   input  logic        sof,
   input  logic        abort,
   output logic [28:0] identifier,
   output logic        extended,
   output logic        remote,
   output logic [3:0]  datalen,
   output logic [3:0]  rmlen,
   output logic [63:0] data,
   output logic [14:0] crc_rx,
   output logic        crc_en,
   output logic        dlc_done,
   output logic        frame_done
);
   import can_pkg::*;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [28:0]      r_id;
   logic             r_ext;
   logic             r_rem;
   logic             r_rtr_tmp;
   logic [3:0]       r_dlc;
   logic [3:0]       r_rmlen;
   logic [63:0]      r_data;
   logic [14:0]      r_crc;
   logic             r_crc_en;
   logic             r_dlc_done;
   logic             r_frame_done;

   logic [CNT_W-1:0] w_cnt;
   logic [CNT_W-1:0] w_last;
   logic             w_tc;
   logic             w_clr;
   logic             w_start;
   logic [3:0]       w_dlc_nxt;
   logic [3:0]       w_rmlen_nxt;

   assign w_start     = sof & bit_valid;
   assign w_dlc_nxt   = {r_dlc[2:0], bit_in};
   assign w_rmlen_nxt = real_len(w_dlc_nxt, r_rem, MAX_BYTES);
   assign w_clr       = abort | (bit_valid & (sof | w_tc)) | (r_state == S_IDLE);

   decap_fieldcnt u_fieldcnt (
      .clock  (clock),
      .reset  (reset),
      .i_clr  (w_clr),
      .i_inc  (bit_valid),
      .i_last (w_last),
      .o_cnt  (w_cnt),
      .o_tc   (w_tc)
   );

   always_comb begin
      w_last = '0;
      case (r_state)
         S_ID_A:  w_last = CNT_W'(ID_A_W - 1);
         S_ID_B:  w_last = CNT_W'(ID_B_W - 1);
         S_DLC:   w_last = CNT_W'(DLC_W - 1);
         // rmlen 1..8 maps to 7..63; rmlen=8 wraps its low bits to 0 first.
         S_DATA:  w_last = {r_rmlen[2:0] - 3'd1, 3'b111};
         S_CRC:   w_last = CNT_W'(CRC_W - 1);
         default: w_last = '0;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      if (abort) begin
         w_state_nxt = S_IDLE;
      end else if (w_start) begin
         w_state_nxt = S_ID_A;
      end else if (bit_valid && w_tc) begin
         case (r_state)
            S_ID_A:  w_state_nxt = S_BIT12;
            S_BIT12: w_state_nxt = S_IDE;
            S_IDE:   w_state_nxt = bit_in ? S_ID_B : S_R0;
            S_ID_B:  w_state_nxt = S_RTR;
            S_RTR:   w_state_nxt = S_R1;
            S_R1:    w_state_nxt = S_R0;
            S_R0:    w_state_nxt = S_DLC;
            S_DLC:   w_state_nxt = (w_rmlen_nxt == 4'd0) ? S_CRC : S_DATA;
            S_DATA:  w_state_nxt = S_CRC;
            S_CRC:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_id         <= '0;
         r_ext        <= 1'b0;
         r_rem        <= 1'b0;
         r_rtr_tmp    <= 1'b0;
         r_dlc        <= '0;
         r_rmlen      <= '0;
         r_data       <= '0;
         r_crc        <= '0;
         r_crc_en     <= 1'b0;
         r_dlc_done   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_crc_en     <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_CRC);
         r_dlc_done   <= 1'b0;
         r_frame_done <= 1'b0;
         if (abort) begin
            // Partial field values are left in place for diagnosis.
         end else if (w_start) begin
            r_id      <= '0;
            r_ext     <= 1'b0;
            r_rem     <= 1'b0;
            r_rtr_tmp <= 1'b0;
            r_dlc     <= '0;
            r_data    <= '0;
            r_crc     <= '0;
         end else if (bit_valid) begin
            case (r_state)
               S_ID_A:  r_id[28:18] <= {r_id[27:18], bit_in};
               S_BIT12: r_rtr_tmp <= bit_in;
               S_IDE: begin
                  r_ext <= bit_in;
                  if (!bit_in) r_rem <= r_rtr_tmp;
               end
               S_ID_B:  r_id[17:0] <= {r_id[16:0], bit_in};
               S_RTR:   r_rem <= bit_in;
               S_DLC: begin
                  r_dlc <= w_dlc_nxt;
                  if (w_tc) begin
                     r_rmlen    <= w_rmlen_nxt;
                     r_dlc_done <= 1'b1;
                  end
               end
               S_DATA:  r_data[6'd63 - w_cnt] <= bit_in;
               S_CRC: begin
                  r_crc <= {r_crc[13:0], bit_in};
                  if (w_tc) r_frame_done <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign identifier = r_id;
   assign extended   = r_ext;
   assign remote     = r_rem;
   assign datalen    = r_dlc;
   assign rmlen      = r_rmlen;
   assign data       = r_data;
   assign crc_rx     = r_crc;
   assign crc_en     = r_crc_en;
   assign dlc_done   = r_dlc_done;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_decapsulation2.sv
// Directed-frame bench for decapsulation2: a driver serialises frames, a
// monitor pops expected field values on dlc_done / frame_done and compares.
module tb_decapsulation2;

   logic        clock;
   logic        reset;
   logic        bit_in;
   logic        bit_valid;
   logic        sof;
   logic        abort;
   logic [28:0] identifier;
   logic        extended;
   logic        remote;
   logic [3:0]  datalen;
   logic [3:0]  rmlen;
   logic [63:0] data;
   logic [14:0] crc_rx;
   logic        crc_en;
   logic        dlc_done;
   logic        frame_done;

   typedef struct {
      logic [28:0] id;
      logic        ext;
      logic        rem;
      logic [3:0]  dlc;
      logic [3:0]  rml;
      logic [63:0] data;
      logic [14:0] crc;
      int          bits;
   } exp_t;

   exp_t exp_q[$];
   exp_t dlc_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   n_bits = 0;

   decapsulation2 dut (
      .clock      (clock),
      .reset      (reset),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .sof        (sof),
      .abort      (abort),
      .identifier (identifier),
      .extended   (extended),
      .remote     (remote),
      .datalen    (datalen),
      .rmlen      (rmlen),
      .data       (data),
      .crc_rx     (crc_rx),
      .crc_en     (crc_en),
      .dlc_done   (dlc_done),
      .frame_done (frame_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " identifier"}, 64'(identifier), 64'd0);
      chk({tag, " extended"},   64'(extended),   64'd0);
      chk({tag, " remote"},     64'(remote),     64'd0);
      chk({tag, " datalen"},    64'(datalen),    64'd0);
      chk({tag, " rmlen"},      64'(rmlen),      64'd0);
      chk({tag, " data"},       data,            64'd0);
      chk({tag, " crc_rx"},     64'(crc_rx),     64'd0);
      chk({tag, " crc_en"},     64'(crc_en),     64'd0);
      chk({tag, " dlc_done"},   64'(dlc_done),   64'd0);
      chk({tag, " frame_done"}, 64'(frame_done), 64'd0);
   endtask

   task automatic push_dlc(input logic [3:0] dlc, input logic [3:0] rml, input int bits);
      exp_t e;
      e = '{id: '0, ext: 1'b0, rem: 1'b0, dlc: dlc, rml: rml, data: '0, crc: '0, bits: bits};
      dlc_q.push_back(e);
   endtask

   task automatic push_frame(input logic [28:0] id, input logic ext, input logic rem,
                             input logic [3:0] dlc, input logic [3:0] rml,
                             input logic [63:0] dat, input logic [14:0] crc,
                             input int bits, input int dlc_bits);
      exp_t e;
      e = '{id: id, ext: ext, rem: rem, dlc: dlc, rml: rml, data: dat, crc: crc, bits: bits};
      exp_q.push_back(e);
      push_dlc(dlc, rml, dlc_bits);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         bit_valid = 1'b0;
         sof       = 1'b0;
         @(posedge clock);
      end
   endtask

   task automatic drive_bit(input logic b, input logic s);
      @(negedge clock);
      bit_valid = 1'b1;
      bit_in    = b;
      sof       = s;
      @(posedge clock);
      n_bits++;
   endtask

   // Serialises one frame; basic ids are passed in id[10:0].
   task automatic send_frame(input logic [28:0] id, input logic ext, input logic rtr,
                             input logic [3:0] dlc, input logic [63:0] dat, input int nbytes,
                             input logic [14:0] crc, input int gap_max, input int stop_after);
      logic        q[$];
      logic [10:0] ida;
      logic [17:0] idb;
      int          nsend;
      ida = ext ? id[28:18] : id[10:0];
      idb = id[17:0];
      q.push_back(1'b0);
      for (int i = 10; i >= 0; i--) q.push_back(ida[i]);
      q.push_back(ext ? 1'b1 : rtr);
      q.push_back(ext);
      if (ext) begin
         for (int i = 17; i >= 0; i--) q.push_back(idb[i]);
         q.push_back(rtr);
         q.push_back(1'b0);
      end
      q.push_back(1'b0);
      for (int i = 3; i >= 0; i--) q.push_back(dlc[i]);
      for (int i = 0; i < 8 * nbytes; i++) q.push_back(dat[63 - i]);
      for (int i = 14; i >= 0; i--) q.push_back(crc[i]);
      nsend  = (stop_after > 0) ? stop_after : q.size();
      n_bits = 0;
      for (int i = 0; i < nsend; i++) begin
         if (gap_max > 0) idle($urandom_range(0, gap_max));
         drive_bit(q[i], i == 0);
      end
      idle(1);
   endtask

   exp_t mon_e;
   always @(negedge clock) begin
      if (reset) begin
         if (dlc_done) begin
            if (dlc_q.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL dlc_done: unexpected pulse at bit %0d", n_bits);
            end else begin
               mon_e = dlc_q.pop_front();
               chk("dlc_done bit", 64'(n_bits), 64'(mon_e.bits));
               chk("dlc_done datalen", 64'(datalen), 64'(mon_e.dlc));
               chk("dlc_done rmlen", 64'(rmlen), 64'(mon_e.rml));
            end
         end
         if (frame_done) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL frame_done: unexpected pulse at bit %0d", n_bits);
            end else begin
               mon_e = exp_q.pop_front();
               chk("frame bit", 64'(n_bits), 64'(mon_e.bits));
               chk("identifier", 64'(identifier), 64'(mon_e.id));
               chk("extended", 64'(extended), 64'(mon_e.ext));
               chk("remote", 64'(remote), 64'(mon_e.rem));
               chk("datalen", 64'(datalen), 64'(mon_e.dlc));
               chk("rmlen", 64'(rmlen), 64'(mon_e.rml));
               chk("data", data, mon_e.data);
               chk("crc_rx", 64'(crc_rx), 64'(mon_e.crc));
            end
         end
      end
   end

   initial begin
      reset     = 1'b0;
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      sof       = 1'b0;
      abort     = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk_zero("reset");
      reset = 1'b1;
      idle(2);

      // Basic data frame, gap-free.
      push_frame(29'h048C0000, 1'b0, 1'b0, 4'd2, 4'd2, 64'hA55A_0000_0000_0000, 15'h1234, 50, 19);
      send_frame(29'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 2, 15'h1234, 0, 0);
      idle(4);
      @(negedge clock);
      chk("hold identifier", 64'(identifier), 64'h048C0000);
      chk("hold crc_en", 64'(crc_en), 64'd0);

      // Extended remote frame, DLC ignored for data.
      push_frame(29'h1ABCDEF5, 1'b1, 1'b1, 4'd5, 4'd0, 64'd0, 15'h7FFF, 54, 39);
      send_frame(29'h1ABCDEF5, 1'b1, 1'b1, 4'd5, 64'd0, 0, 15'h7FFF, 0, 0);
      idle(3);

      // DLC 15 clips to 8 bytes.
      push_frame(29'h15540000, 1'b0, 1'b0, 4'd15, 4'd8, 64'h0123456789ABCDEF, 15'h0ABC, 98, 19);
      send_frame(29'h555, 1'b0, 1'b0, 4'd15, 64'h0123456789ABCDEF, 8, 15'h0ABC, 0, 0);
      idle(3);

      // Basic remote with non-zero DLC.
      push_frame(29'h04000000, 1'b0, 1'b1, 4'd8, 4'd0, 64'd0, 15'h2AAA, 34, 19);
      send_frame(29'h100, 1'b0, 1'b1, 4'd8, 64'd0, 0, 15'h2AAA, 0, 0);
      idle(3);

      // First frame again with random bit_valid gaps.
      push_frame(29'h048C0000, 1'b0, 1'b0, 4'd2, 4'd2, 64'hA55A_0000_0000_0000, 15'h1234, 50, 19);
      send_frame(29'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 2, 15'h1234, 5, 0);
      idle(3);

      // Abort inside DATA: only dlc_done is expected from this frame.
      push_dlc(4'd3, 4'd3, 19);
      send_frame(29'h2AA, 1'b0, 1'b0, 4'd3, 64'hFFFF_FF00_0000_0000, 3, 15'h0F0F, 0, 24);
      @(negedge clock);
      abort = 1'b1;
      @(posedge clock);
      @(negedge clock);
      abort = 1'b0;
      chk("abort crc_en", 64'(crc_en), 64'd0);
      chk("abort datalen held", 64'(datalen), 64'd3);
      idle(20);
      push_frame(29'h1FFC0000, 1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 15'h0001, 34, 19);
      send_frame(29'h7FF, 1'b0, 1'b0, 4'd0, 64'd0, 0, 15'h0001, 0, 0);
      idle(3);

      // Reset while inside the extended identifier.
      send_frame(29'h15555555, 1'b1, 1'b0, 4'd2, 64'd0, 0, 15'h0000, 0, 25);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk_zero("midreset");
      reset = 1'b1;
      idle(2);
      push_frame(29'h00040000, 1'b0, 1'b0, 4'd1, 4'd1, 64'h8000_0000_0000_0000, 15'h4001, 42, 19);
      send_frame(29'h001, 1'b0, 1'b0, 4'd1, 64'h8000_0000_0000_0000, 1, 15'h4001, 0, 0);

      for (int i = 0; i < 50 && (exp_q.size() != 0 || dlc_q.size() != 0); i++)
         @(negedge clock);
      n_vec++;
      if (exp_q.size() != 0 || dlc_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: %0d frame and %0d dlc expectations left, required 0",
                  exp_q.size(), dlc_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
